// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//  - state_e   : sequencer FSM states (3-bit encoding)
//  - cnt_width : width of the shared down-counter for a given set of cycle counts
//  - Def*      : default cycle constants for the sequencer parameters
package rst_seq_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAssert  = 3'd1,
    StRelease = 3'd2,
    StWaitRdy = 3'd3,
    StGap     = 3'd4,
    StDone    = 3'd5,
    StErr     = 3'd6
  } state_e;

  localparam int unsigned DefNumDom  = 4;
  localparam int unsigned DefHoldCyc = 16;
  localparam int unsigned DefGapCyc  = 8;
  localparam int unsigned DefTmoCyc  = 1024;

  // clog2 of the largest interval plus one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned hold_cyc,
                                            input int unsigned gap_cyc,
                                            input int unsigned tmo_cyc);
    int unsigned m;
    m = hold_cyc;
    if (gap_cyc > m) m = gap_cyc;
    if (tmo_cyc > m) m = tmo_cyc;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter with zero flag, used to time the sequencer states.
// Ports:
//  clk      in   clock
//  rst      in   synchronous reset, active-high (clears the count)
//  load     in   load load_val (has priority over dec)
//  dec      in   decrement by one; holds at zero, never wraps
//  load_val in   value to load
//  zero     out  count is zero
module rst_seq_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer. On start_i all domain resets are asserted for HOLD_CYC cycles, then each
// domain is released in index order; the next release waits for the current domain's ready
// plus a GAP_CYC gap. A restart is possible at any time via start_i.
// Optional feature: define RST_SEQ_TIMEOUT_EN to enable a TMO_CYC ready-wait timeout that
// ends in an error state (err_o/err_dom_o). Without it the wait is unbounded and the error
// outputs stay 0.
// Ports:
//  clk          in   system clock
//  rst          in   synchronous reset, active-high
//  start_i      in   single-cycle start pulse
//  dom_ready_i  in   per-domain ready level
//  dom_rst_n_o  out  per-domain reset, active-low, registered
//  busy_o       out  sequence in progress
//  done_o       out  all domains released and ready
//  err_o        out  ready timeout occurred
//  err_dom_o    out  index of the domain that timed out
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOM  = DefNumDom,
  parameter int unsigned HOLD_CYC = DefHoldCyc,
  parameter int unsigned GAP_CYC  = DefGapCyc,
  parameter int unsigned TMO_CYC  = DefTmoCyc
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start_i,
  input  logic [NUM_DOM-1:0]                             dom_ready_i,
  output logic [NUM_DOM-1:0]                             dom_rst_n_o,
  output logic                                           busy_o,
  output logic                                           done_o,
  output logic                                           err_o,
  output logic [((NUM_DOM > 1) ? $clog2(NUM_DOM) : 1)-1:0] err_dom_o
);

  localparam int unsigned IdxW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int unsigned CntW = cnt_width(HOLD_CYC, GAP_CYC, TMO_CYC);

  // The counter exits a state when it reads zero, so an N-cycle state loads N-1.
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYC - 1);
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TmoLoad  = CntW'(TMO_CYC - 1);
`endif
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_DOM - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [NUM_DOM-1:0]  rst_n_q, rst_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [IdxW-1:0]     err_dom_q, err_dom_d;

  logic                cnt_load, cnt_dec, cnt_zero;
  logic [CntW-1:0]     cnt_val;

  rst_seq_cnt #(
    .Width (CntW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rst_n_d   = rst_n_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    err_dom_d = err_dom_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;

    if (start_i) begin
      // Start (or restart from any state) always begins a full sequence.
      state_d  = StAssert;
      idx_d    = '0;
      rst_n_d  = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      err_d    = 1'b0;
      cnt_load = 1'b1;
      cnt_val  = HoldLoad;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (cnt_zero) begin
            state_d  = StRelease;
            cnt_load = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        StRelease: begin
          rst_n_d[idx_q] = 1'b1;
          state_d        = StWaitRdy;
          cnt_load       = 1'b1;
`ifdef RST_SEQ_TIMEOUT_EN
          cnt_val        = TmoLoad;
`endif
        end
        StWaitRdy: begin
          // Only the domain just released is looked at.
          if (dom_ready_i[idx_q]) begin
            if (idx_q == LastIdx) begin
              state_d = StDone;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d  = StGap;
              cnt_load = 1'b1;
              cnt_val  = GapLoad;
            end
          end
`ifdef RST_SEQ_TIMEOUT_EN
          else if (cnt_zero) begin
            state_d   = StErr;
            err_d     = 1'b1;
            err_dom_d = idx_q;
            rst_n_d   = '0;
            busy_d    = 1'b0;
          end else begin
            cnt_dec = 1'b1;
          end
`endif
        end
        StGap: begin
          if (cnt_zero) begin
            state_d  = StRelease;
            idx_d    = idx_q + IdxW'(1);
            cnt_load = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rst_n_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_dom_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rst_n_q   <= rst_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_dom_q <= err_dom_d;
    end
  end

  assign dom_rst_n_o = rst_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_dom_o   = err_dom_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl. A timestamp model tracks, per domain, the edge at which its reset
// is released and the edge at which its ready was accepted; expected outputs are derived from
// those timestamps every cycle. Directed scenarios are followed by randomized runs.
module tb_rst_seq_ctrl;

  localparam int NumDom  = 4;
  localparam int HoldCyc = 16;
  localparam int GapCyc  = 8;
  localparam int TmoCyc  = 1024;
  localparam int IdxW    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NumDom-1:0] dom_ready;
  logic [NumDom-1:0] dom_rst_n;
  logic              busy, done, err;
  logic [IdxW-1:0]   err_dom;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .NUM_DOM  (NumDom),
    .HOLD_CYC (HoldCyc),
    .GAP_CYC  (GapCyc),
    .TMO_CYC  (TmoCyc)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .dom_ready_i (dom_ready),
    .dom_rst_n_o (dom_rst_n),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_dom_o   (err_dom)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Model: edge numbers of release / acceptance per domain (-1 = not yet).
  int t = 0;
  int m_t0 = 0;
  int rel [NumDom];
  int acc [NumDom];
  bit m_active = 0, m_done = 0, m_err = 0;
  int m_err_dom = 0;

  // Stimulus knobs.
  int dly [NumDom];   // ready comes this many cycles after the first WAIT sample point
  int noise_mode = 0; // ready of idle domains: 0 random, 1 high, 2 low
  int done_edge = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, t);
    end
  endtask

  function automatic void clear_model();
    for (int i = 0; i < NumDom; i++) begin
      rel[i] = -1;
      acc[i] = -1;
    end
  endfunction

  function automatic int cur_dom();
    for (int i = 0; i < NumDom; i++) if (acc[i] < 0) return i;
    return NumDom;
  endfunction

  function automatic void model_update(input bit s, input bit r, input logic [NumDom-1:0] rdy);
    int k;
    if (r) begin
      clear_model();
      m_active = 0; m_done = 0; m_err = 0; m_err_dom = 0;
    end else if (s) begin
      clear_model();
      m_active = 1; m_done = 0; m_err = 0;
      m_t0 = t;
      rel[0] = t + HoldCyc + 1;
    end else if (m_active) begin
      k = cur_dom();
      if (k < NumDom && rel[k] >= 0 && t > rel[k]) begin
        if (rdy[k]) begin
          acc[k] = t;
          if (k == NumDom - 1) begin
            m_done = 1; m_active = 0;
          end else begin
            rel[k+1] = t + GapCyc + 1;
          end
        end
`ifdef RST_SEQ_TIMEOUT_EN
        else if (t == rel[k] + TmoCyc) begin
          m_err = 1; m_err_dom = k; m_active = 0;
          clear_model();
        end
`endif
      end
    end
  endfunction

  function automatic logic [NumDom-1:0] exp_rst_n();
    logic [NumDom-1:0] v;
    for (int i = 0; i < NumDom; i++) v[i] = (rel[i] >= 0 && t >= rel[i]);
    return v;
  endfunction

  function automatic logic [NumDom-1:0] gen_ready();
    logic [NumDom-1:0] v;
    int tn;
    tn = t + 1;
    for (int i = 0; i < NumDom; i++) begin
      if (rel[i] >= 0 && tn > rel[i] && acc[i] < 0 && m_active) v[i] = (tn >= rel[i] + 1 + dly[i]);
      else if (noise_mode == 1) v[i] = 1'b1;
      else if (noise_mode == 2) v[i] = 1'b0;
      else v[i] = 1'($urandom_range(1, 0));
    end
    return v;
  endfunction

  // One clock: drive inputs, advance the model on the edge, compare at the falling edge.
  task automatic step(input bit s, input bit r);
    logic [NumDom-1:0] rdy;
    rdy = gen_ready();
    start = s; rst = r; dom_ready = rdy;
    @(posedge clk);
    t++;
    model_update(s, r, rdy);
    if (s || r) done_edge = -1;
    @(negedge clk);
    check_eq("rst_n", 32'(dom_rst_n), 32'(exp_rst_n()));
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("err_dom", 32'(err_dom), 32'(m_err_dom));
    if (done === 1'b1 && done_edge < 0) done_edge = t;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!m_done && n < budget) begin
      step(0, 0);
      n++;
    end
    check_eq(tag, 32'(done), 32'(1));
  endtask

  function automatic int nominal_latency(input int d);
    return HoldCyc + 1 + (NumDom - 1) * (1 + d + GapCyc + 1) + 1 + d;
  endfunction

  initial begin
    int n;
    clear_model();
    for (int i = 0; i < NumDom; i++) dly[i] = 0;
    rst = 1'b1; start = 1'b0; dom_ready = '0;

    // Reset state.
    repeat (3) step(0, 1);
    repeat (2) step(0, 0);

    // 1: nominal, ready 3 cycles after each release.
    noise_mode = 2;
    for (int i = 0; i < NumDom; i++) dly[i] = 3;
    step(1, 0);
    run_until_done(200, "t1_done");
    check_eq("t1_latency", 32'(done_edge - m_t0), 32'(nominal_latency(3)));
    repeat (3) step(0, 0);

    // 2: all ready high before start.
    noise_mode = 1;
    for (int i = 0; i < NumDom; i++) dly[i] = 0;
    repeat (2) step(0, 0);
    step(1, 0);
    run_until_done(200, "t2_done");
    check_eq("t2_latency", 32'(done_edge - m_t0), 32'(48));
    repeat (3) step(0, 0);

    // 3: restart during the gap after domain 1.
    noise_mode = 0;
    for (int i = 0; i < NumDom; i++) dly[i] = 2;
    step(1, 0);
    n = 0;
    while (acc[1] < 0 && n < 200) begin step(0, 0); n++; end
    step(0, 0);
    check_eq("t3_busy_in_gap", 32'(busy), 32'(1));
    step(1, 0);
    check_eq("t3_all_held", 32'(dom_rst_n), 32'(0));
    run_until_done(300, "t3_done");
    check_eq("t3_latency", 32'(done_edge - m_t0), 32'(nominal_latency(2)));

    // 5: reset during WAIT_RDY of domain 1, then a clean sequence.
    dly[1] = 20;
    step(1, 0);
    n = 0;
    while (!(rel[1] >= 0 && t > rel[1]) && n < 200) begin step(0, 0); n++; end
    step(0, 0);
    step(0, 1);
    check_eq("t5_rst_n", 32'(dom_rst_n), 32'(0));
    check_eq("t5_busy", 32'(busy), 32'(0));
    repeat (4) step(0, 0);
    dly[1] = 2;
    step(1, 0);
    run_until_done(300, "t5_done");

`ifdef RST_SEQ_TIMEOUT_EN
    // 4: domain 2 never ready -> timeout, then a fresh start clears the error.
    noise_mode = 2;
    dly[2] = 100000;
    step(1, 0);
    n = 0;
    while (!m_err && n < 2000) begin step(0, 0); n++; end
    check_eq("t4_err", 32'(err), 32'(1));
    check_eq("t4_err_dom", 32'(err_dom), 32'(2));
    dly[2] = 1;
    step(1, 0);
    check_eq("t4_err_clr", 32'(err), 32'(0));
    run_until_done(300, "t4_done");
`else
    // 6: no timeout -> indefinite wait on domain 0, then resume.
    noise_mode = 2;
    dly[0] = 100000;
    step(1, 0);
    repeat (5000) step(0, 0);
    check_eq("t6_err", 32'(err), 32'(0));
    check_eq("t6_busy", 32'(busy), 32'(1));
    check_eq("t6_rst_n", 32'(dom_rst_n), 32'(1));
    dly[0] = 0;
    run_until_done(300, "t6_done");
`endif

    // Randomized runs with random delays, noise, restarts and resets.
    for (int it = 0; it < 30; it++) begin
      noise_mode = int'($urandom_range(2, 0));
      for (int i = 0; i < NumDom; i++) dly[i] = int'($urandom_range(6, 0));
      step(1, 0);
      n = 0;
      while (n < 150 && !(m_done && n > 100)) begin
        step($urandom_range(79, 0) == 0, $urandom_range(119, 0) == 0);
        n++;
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", t);
    $fatal(1, "watchdog");
  end

endmodule
